// File: rtl/lane_serializer.sv
// Warp mask serializer: emits the index of each active lane, lowest first, one
// beat per cycle over a valid/ready stream, with first/last/count sideband.

module popcnt #(
    parameter int WIDTH  = 32,
    parameter int CWIDTH = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0]  mask,
    output logic [CWIDTH-1:0] cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) cnt = cnt + CWIDTH'(mask[i]);
    end
endmodule

module lane_serializer #(
    parameter int WIDTH  = 32,
    parameter int TAGW   = 5,
    parameter int IDXW   = $clog2(WIDTH),
    parameter int CWIDTH = $clog2(WIDTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_mask,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDXW-1:0]   out_lane,
    output logic [TAGW-1:0]   out_tag,
    output logic              out_first,
    output logic              out_last,
    output logic [CWIDTH-1:0] active_cnt,
    output logic [CWIDTH-1:0] remaining,
    output logic              empty_drop
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  pend;
    logic [TAGW-1:0]   tag_q;
    logic [CWIDTH-1:0] cnt_q, rem_q, in_cnt;
    logic              drop_q;
    logic              hs, acc, mask_nz;

    popcnt #(.WIDTH(WIDTH), .CWIDTH(CWIDTH)) u_popcnt (.mask(in_mask), .cnt(in_cnt));

    assign out_valid  = (state == EMIT);
    assign hs         = out_valid & out_ready;
    // Accepting on the last beat lets the next mask follow with no idle cycle.
    assign in_ready   = (state == IDLE) | (hs & out_last);
    assign acc        = in_valid & in_ready;
    assign mask_nz    = |in_mask;
    assign out_tag    = tag_q;
    assign active_cnt = cnt_q;
    assign remaining  = rem_q;
    assign empty_drop = drop_q;
    assign out_first  = out_valid & (rem_q == cnt_q);
    assign out_last   = out_valid & (rem_q == CWIDTH'(1));

    always_comb begin
        out_lane = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (pend[i]) out_lane = IDXW'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (acc && mask_nz) state_nxt = EMIT;
            EMIT: if (hs && out_last) state_nxt = (acc && mask_nz) ? EMIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= '0;
            tag_q  <= '0;
            cnt_q  <= '0;
            rem_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= acc & ~mask_nz;
            if (acc) begin
                pend  <= in_mask;
                tag_q <= in_tag;
                cnt_q <= in_cnt;
                rem_q <= in_cnt;
            end else if (hs) begin
                // x & (x-1) strips the lowest set bit, i.e. the lane just sent.
                pend  <= pend & (pend - 1'b1);
                rem_q <= rem_q - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lane_serializer.sv
// Bench for lane_serializer: table vectors, directed corner sequences and
// random traffic checked against a queue-based beat model.

module tb_lane_serializer;
    localparam int WIDTH = 32, TAGW = 5, IDXW = 5, CWIDTH = 6;

    logic              clk = 0, rst_n = 0;
    logic              in_valid = 0, in_ready, out_valid, out_ready = 1;
    logic [WIDTH-1:0]  in_mask = '0;
    logic [TAGW-1:0]   in_tag = '0, out_tag;
    logic [IDXW-1:0]   out_lane;
    logic              out_first, out_last, empty_drop;
    logic [CWIDTH-1:0] active_cnt, remaining;

    int checks = 0, errors = 0;

    lane_serializer #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mask(in_mask), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_lane(out_lane), .out_tag(out_tag), .out_first(out_first), .out_last(out_last),
        .active_cnt(active_cnt), .remaining(remaining), .empty_drop(empty_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: each accepted mask expands into its list of beats.
    typedef struct {int lane; int tag; bit first; bit last; int cnt; int rem;} beat_t;
    beat_t q[$];
    bit    drop_exp = 0;
    int    last_cnt = 0;

    always @(negedge clk) begin
        #3;
        if (!rst_n) begin
            q.delete();
            drop_exp = 0;
            last_cnt = 0;
        end else begin
            bit rdy_exp;
            rdy_exp = (q.size() == 0) || (q.size() == 1 && out_ready);
            chk("empty_drop", empty_drop, drop_exp);
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, rdy_exp);
            chk("active_cnt", active_cnt, last_cnt);
            if (q.size() == 0) begin
                chk("remaining_idle", remaining, 0);
            end else begin
                chk("out_lane", out_lane, q[0].lane);
                chk("out_tag", out_tag, q[0].tag);
                chk("out_first", out_first, q[0].first);
                chk("out_last", out_last, q[0].last);
                chk("remaining", remaining, q[0].rem);
                if (out_ready) void'(q.pop_front());
            end
            drop_exp = 0;
            if (in_valid && rdy_exp) begin
                int n, k;
                n = 0;
                for (int i = 0; i < WIDTH; i++) n += in_mask[i];
                k = 0;
                for (int i = 0; i < WIDTH; i++)
                    if (in_mask[i]) begin
                        q.push_back('{i, int'(in_tag), k == 0, k == n - 1, n, n - k});
                        k++;
                    end
                last_cnt = n;
                drop_exp = (n == 0);
            end
        end
    end

    // Offer a mask at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [WIDTH-1:0] m, input logic [TAGW-1:0] t);
        bit ok = 0;
        @(negedge clk);
        in_valid = 1; in_mask = m; in_tag = t;
        for (int k = 0; k < 200 && !ok; k++) begin
            #1;
            ok = in_ready;
            @(negedge clk);
        end
        in_valid = 0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    typedef struct {logic [WIDTH-1:0] mask; logic [TAGW-1:0] tag; int cnt; int first_lane; int last_lane;} vec_t;
    vec_t tbl[7];
    bit   rand_ready = 0;

    initial begin
        tbl[0] = '{32'h0000_0013, 5'd3,  3,  0,  4};
        tbl[1] = '{32'h0000_0000, 5'd7,  0, -1, -1};
        tbl[2] = '{32'hFFFF_FFFF, 5'd9,  32, 0, 31};
        tbl[3] = '{32'h8000_0000, 5'd2,  1, 31, 31};
        tbl[4] = '{32'h0000_0001, 5'd31, 1,  0,  0};
        tbl[5] = '{32'hA000_0005, 5'd12, 4,  0, 31};
        tbl[6] = '{32'h0001_8000, 5'd0,  2, 15, 16};

        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_active_cnt", active_cnt, 0);
        chk("rst_empty_drop", empty_drop, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        #1 chk("rst_in_ready", in_ready, 1);

        // Table vectors with out_ready held high.
        foreach (tbl[v]) begin
            int nb, fl, ll, drops;
            nb = 0; fl = -1; ll = -1; drops = 0;
            send(tbl[v].mask, tbl[v].tag);
            for (int k = 0; k < 60; k++) begin
                #2;
                if (empty_drop) drops++;
                if (out_valid) begin
                    if (nb == 0) fl = out_lane;
                    ll = out_lane;
                    nb++;
                end
                if (out_valid && out_last) break;
                if (!out_valid && k > 2) break;
                @(negedge clk);
            end
            chk("tbl_beats", nb, tbl[v].cnt);
            chk("tbl_first_lane", fl, tbl[v].first_lane);
            chk("tbl_last_lane", ll, tbl[v].last_lane);
            if (tbl[v].cnt == 0) chk("tbl_drop_pulses", drops, 1);
            @(negedge clk);
        end

        // Stall on lane 1 for four cycles.
        send(32'h0000_0013, 5'd3);
        @(negedge clk);
        out_ready = 0;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("stall_valid", out_valid, 1);
            chk("stall_lane", out_lane, 1);
            chk("stall_rem", remaining, 2);
            @(negedge clk);
        end
        out_ready = 1;
        #2 chk("stall_resume_lane", out_lane, 1);
        @(negedge clk);
        #2 chk("stall_next_lane", out_lane, 4);
        chk("stall_next_last", out_last, 1);
        @(negedge clk);
        #2 chk("stall_done", out_valid, 0);

        // Back-to-back masks: second accepted on the last beat of the first.
        @(negedge clk);
        in_valid = 1; in_mask = 32'h0000_0005; in_tag = 5'd1;
        @(negedge clk);
        in_mask = 32'h8000_0000; in_tag = 5'd2;
        #2 chk("b2b_lane0", out_lane, 0);
        chk("b2b_ready0", in_ready, 0);
        @(negedge clk);
        #2 chk("b2b_lane2", out_lane, 2);
        chk("b2b_last2", out_last, 1);
        chk("b2b_ready2", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        #2 chk("b2b_valid31", out_valid, 1);
        chk("b2b_lane31", out_lane, 31);
        chk("b2b_tag", out_tag, 2);
        chk("b2b_first31", out_first, 1);
        @(negedge clk);
        #2 chk("b2b_idle", out_valid, 0);

        // Reset in the middle of a mask.
        send(32'h0000_0013, 5'd3);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_lane", out_lane, 0);
        chk("mrst_tag", out_tag, 0);
        chk("mrst_rem", remaining, 0);
        chk("mrst_cnt", active_cnt, 0);
        chk("mrst_first", out_first, 0);
        chk("mrst_last", out_last, 0);
        @(negedge clk);
        rst_n = 1;
        #1 chk("mrst_in_ready", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #2 chk("mrst_no_stale", out_valid, 0);
        end

        // Random traffic with random backpressure; the model checks every cycle.
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    logic [WIDTH-1:0] m;
                    int sel;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    sel = $urandom_range(0, 9);
                    case (sel)
                        0:       m = '0;
                        1:       m = '1;
                        2, 3:    m = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
                        4, 5, 6: m = $urandom & $urandom & $urandom;
                        default: m = $urandom;
                    endcase
                    send(m, TAGW'($urandom_range(0, 31)));
                end
                for (int k = 0; k < 300 && q.size() != 0; k++) @(negedge clk);
                chk("rand_drain", q.size(), 0);
                rand_ready = 0;
            end
            begin
                rand_ready = 1;
                while (rand_ready) begin
                    @(negedge clk);
                    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
            end
        join
        out_ready = 1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
